// File: rtl/bcd_conversion_arbiter.sv
// bcd_conversion_arbiter: round-robin sharing of one binary-to-BCD converter between NUM_REQ requesters
// Ports: clk_i/reset_i (sync active-high); req_i/binary_i requester side;
// done_o (one-hot pulse), bcd_o (held result), err_o (timeout pulse), busy_o, owner_o;
// conv_start_o/conv_binary_o/conv_ready_i/conv_done_i/conv_bcd_i converter side.
module bcd_conversion_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int N       = 16,
  parameter int BCD_N   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*N-1:0]       binary_i,
  output logic [NUM_REQ-1:0]         done_o,
  output logic [BCD_N-1:0]           bcd_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       conv_start_o,
  output logic [N-1:0]               conv_binary_o,
  input  logic                       conv_ready_i,
  input  logic                       conv_done_i,
  input  logic [BCD_N-1:0]           conv_bcd_i
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;
  state_t             r_state, w_next;
  logic [OW-1:0]      r_owner, r_rr, w_win;
  logic [N-1:0]       r_operand;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_done;
  logic [BCD_N-1:0]   r_bcd;
  logic               r_err, w_grant, w_capture, w_timeout;
  // Scan downward so the last hit, i.e. the first set bit at or above the rr pointer, wins
  always_comb begin
    w_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_i[(int'(r_rr) + i) % NUM_REQ]) w_win = OW'((int'(r_rr) + i) % NUM_REQ);
  end
  // Done has priority over a timeout landing in the same cycle
  assign w_grant   = r_state == S_IDLE && conv_ready_i && |req_i;
  assign w_capture = r_state == S_WAIT && conv_done_i;
  assign w_timeout = r_state == S_WAIT && !conv_done_i && r_cnt == CW'(TIMEOUT - 1);
  always_comb begin
    w_next = r_state;
    w_next = w_grant ? S_START : r_state == S_START ? S_WAIT : (w_capture || w_timeout) ? S_IDLE : r_state;
  end
  always_ff @(posedge clk_i)
    r_state <= reset_i ? S_IDLE : w_next;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_owner   <= '0;
      r_rr      <= '0;
      r_operand <= '0;
      r_cnt     <= '0;
      r_done    <= '0;
      r_bcd     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_done <= w_capture ? NUM_REQ'(1) << r_owner : '0;
      r_err  <= w_timeout;
      r_cnt  <= r_state == S_START ? '0 : r_state == S_WAIT ? r_cnt + CW'(1) : r_cnt;
      if (w_capture) r_bcd <= conv_bcd_i;
      if (w_grant) begin
        r_owner   <= w_win;
        r_operand <= binary_i[int'(w_win)*N +: N];
        r_rr      <= w_win == OW'(NUM_REQ - 1) ? '0 : w_win + OW'(1);
      end
    end
  end
  assign done_o        = r_done;
  assign bcd_o         = r_bcd;
  assign err_o         = r_err;
  assign busy_o        = r_state != S_IDLE;
  assign owner_o       = r_owner;
  assign conv_start_o  = r_state == S_START;
  assign conv_binary_o = r_operand;
endmodule

// File: doc/bcd_conversion_arbiter.md
Name: bcd_conversion_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one binary-to-BCD converter (shift-add-3 type, N-bit binary in, BCD_N-bit BCD out) between NUM_REQ requesters.
- Typical requesters are the counter/period measurement paths of the auto-scaled frequency counter.
- For each granted requester the block latches that requester's operand, issues the converter start, waits for converter done, and captures the BCD result.
- It then returns the result with a one-cycle done pulse addressed to that requester, plus a watchdog timeout.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- N, 16, binary operand width; must match the converter.
- BCD_N, 32, BCD result width; must match the converter.
- TIMEOUT, 64, max cycles in WAIT before abort (must be > N+2).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; synchronous, active-high.
- req_i  in  NUM_REQ  level request per requester.
- binary_i  in  NUM_REQ*N  packed operands; requester k occupies [k*N +: N].
- done_o  out  NUM_REQ  one-cycle result pulse, one-hot to owner.
- bcd_o  out  BCD_N  registered result; valid while done_o is non-zero, held until the next capture.
- err_o  out  1  one-cycle timeout pulse.
- busy_o  out  1  high in START or WAIT.
- owner_o  out  $clog2(NUM_REQ)  index of current or last granted requester.
- conv_start_o  out  1  converter start.
- conv_binary_o  out  N  converter operand, driven from the latched register.
- conv_ready_i  in  1  converter ready (idle).
- conv_done_i  in  1  converter done; conv_bcd_i is valid in that same cycle.
- conv_bcd_i  in  BCD_N  converter BCD output.

Behaviour:
- Reset (synchronous, active-high, clk_i): state=IDLE; done_o=0; bcd_o=0; err_o=0; busy_o=0; owner_o=0; conv_start_o=0; operand latch=0; rr pointer=0; timeout counter=0.
- Reset asserted mid-conversion aborts immediately. No done_o or err_o pulse is produced. The converter shares reset_i.
- States: IDLE, START, WAIT.
- IDLE:
  - Arbitrates only when conv_ready_i=1 and any req_i bit is set.
  - Winner is the first set req_i bit scanning upward from the rr pointer, with wrap-around.
  - On a win: owner_o<=winner; operand latch<=binary_i[winner]; rr pointer<=winner+1 (wraps NUM_REQ-1 -> 0); go START.
  - If conv_ready_i=0, stay in IDLE regardless of requests.
- START:
  - conv_start_o=1 for exactly this one cycle; conv_binary_o=operand latch.
  - Clear timeout counter; go WAIT.
- WAIT:
  - conv_start_o=0.
  - If conv_done_i=1: bcd_o<=conv_bcd_i; done_o<=one-hot(owner_o) for one cycle; go IDLE.
  - Else increment counter. When the counter reaches TIMEOUT-1 without done: err_o<=1 for one cycle, bcd_o unchanged, no done_o; go IDLE.
  - conv_done_i and timeout in the same cycle: done wins, no err_o.
- conv_done_i in IDLE or START is ignored.
- Latency, with the request sampled in IDLE at cycle t: conv_start_o at t+1; converter done at t+1+N; done_o/bcd_o at t+2+N.
- Next grant: the converter spends one cycle in DONE after done_o, so conv_ready_i returns at t+3+N. Earliest next conv_start_o is t+4+N.
- Request handling:
  - req_i is sampled only at arbitration. Operand changes after grant do not affect the conversion in flight.
  - A requester must deassert req_i in the cycle after its done_o pulse or it will be re-granted in its next round-robin turn.
  - Dropping req_i after grant does not cancel the conversion.
- binary_i of non-requesting ports is don't-care.
- busy_o = (state==START || state==WAIT).

Test Plan:
- Reset, then req_i=3'b001, binary_i[0]=1234, converter model N=16 -> conv_start_o at t+1 with conv_binary_o=1234; done_o=3'b001 at t+18; bcd_o=32'h00001234.
- req_i[1] with binary=65535 -> bcd_o=32'h00065535; done_o=3'b010; owner_o=1; busy_o low after the pulse.
- req_i=3'b111 held continuously after reset -> grant order 0,1,2,0. Successive done_o pulses 001,010,100,001, spaced N+3 cycles apart.
- req_i=3'b101 after a grant to 2 -> next grant 0, then 2. The rr pointer wraps correctly.
- Converter model never asserts conv_done_i -> err_o pulses once TIMEOUT-1 cycles into WAIT; no done_o; bcd_o unchanged; state returns to IDLE and grants the next request.
- reset_i asserted for one cycle during WAIT -> all outputs at reset values on the next cycle; no done_o or err_o; a new request afterwards completes normally.
